// File: rtl/mat_addsub_seq.sv
// rtl/mat_addsub_seq.sv - element-wise FP32 matrix add/subtract sequenced over one shared adder
module mat_addsub_seq #(
    parameter int ROWS = 2,
    parameter int COLS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    A_stb,
    input  logic                    B_stb,
    input  logic                    op,
    input  logic [32*ROWS*COLS-1:0] A,
    input  logic [32*ROWS*COLS-1:0] B,
    output logic                    in_ack,
    output logic                    busy,
    output logic                    result_ready,
    input  logic                    result_ack,
    output logic [32*ROWS*COLS-1:0] result
);
    localparam int N = ROWS * COLS;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_ACK, S_DONE} state_t;
    state_t state, state_nx;

    logic [32*N-1:0] a_reg, b_reg;
    logic            op_reg;
    logic [KW-1:0]   k;
    logic            capture, store, k_step;
    logic            adder_load, adder_ack, adder_rdy;
    logic [31:0]     adder_num1, adder_num2, adder_res;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        capture    = 1'b0;
        store      = 1'b0;
        k_step     = 1'b0;
        adder_load = 1'b0;
        adder_ack  = 1'b0;
        case (state)
            S_IDLE: if (A_stb && B_stb) begin
                capture  = 1'b1;
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                adder_load = 1'b1;
                state_nx   = S_WAIT;
            end
            S_WAIT: if (adder_rdy) begin
                store     = 1'b1;
                adder_ack = 1'b1;
                state_nx  = S_ACK;
            end
            // Keep acknowledging until the adder has actually dropped its result
            S_ACK: begin
                if (adder_rdy) begin
                    adder_ack = 1'b1;
                end else if (k == K_LAST) begin
                    state_nx = S_DONE;
                end else begin
                    k_step   = 1'b1;
                    state_nx = S_LOAD;
                end
            end
            S_DONE: if (result_ack) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign result_ready = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg  <= '0;
            b_reg  <= '0;
            op_reg <= 1'b0;
            k      <= '0;
            in_ack <= 1'b0;
            result <= '0;
        end else begin
            in_ack <= capture;
            if (capture) begin
                a_reg  <= A;
                b_reg  <= B;
                op_reg <= op;
                k      <= '0;
            end
            if (k_step) k <= k + KW'(1);
            if (store) begin
                for (int i = 0; i < N; i++)
                    if (k == KW'(i)) result[i*32 +: 32] <= adder_res;
            end
        end
    end

    // Subtraction is a pure sign flip of B so zero, Inf and NaN invert exactly
    always_comb begin
        adder_num1 = '0;
        adder_num2 = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                adder_num1 = a_reg[i*32 +: 32];
                adder_num2 = b_reg[i*32 +: 32] ^ {op_reg, 31'd0};
            end
        end
    end

    adder u_adder (
        .reset        (reset),
        .clk          (clk),
        .load         (adder_load),
        .Number1      (adder_num1),
        .Number2      (adder_num2),
        .result_ready (adder_rdy),
        .result_ack   (adder_ack),
        .Result       (adder_res)
    );
endmodule

// Multi-cycle IEEE-754 single adder, round-to-nearest-even, subnormals kept, NaN made quiet.
module adder (
    input  logic        reset,
    input  logic        clk,
    input  logic        load,
    input  logic [31:0] Number1,
    input  logic [31:0] Number2,
    output logic        result_ready,
    input  logic        result_ack,
    output logic [31:0] Result
);
    typedef enum logic [2:0] {A_IDLE, A_ALIGN, A_ADD, A_NORM, A_ROUND, A_DONE} astate_t;
    astate_t state, state_nx;

    logic [31:0] n1, n2;
    logic        spec_q, sgn_q, eff_sub_q, neg_zero_q, zero_q;
    logic [31:0] spec_val_q;
    logic [8:0]  exp_q, ne_q;
    logic [26:0] ma_q, mb_q, nm_q;
    logic [27:0] sum_q;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) n = 5'(26 - i);
        return n;
    endfunction

    logic        a_nan, b_nan, a_inf, b_inf, swap, spec_d;
    logic [31:0] big, spec_val_d;
    logic [30:0] sml;
    logic [8:0]  e_big, e_sml, diff;
    logic [26:0] m_big, m_sml, m_sh;

    always_comb begin
        a_nan      = (n1[30:23] == 8'hFF) && (n1[22:0] != 23'd0);
        b_nan      = (n2[30:23] == 8'hFF) && (n2[22:0] != 23'd0);
        a_inf      = (n1[30:23] == 8'hFF) && (n1[22:0] == 23'd0);
        b_inf      = (n2[30:23] == 8'hFF) && (n2[22:0] == 23'd0);
        spec_d     = 1'b1;
        spec_val_d = 32'h7FC00000;
        if (a_nan || b_nan || (a_inf && b_inf && (n1[31] != n2[31]))) spec_val_d = 32'h7FC00000;
        else if (a_inf)                                                 spec_val_d = n1;
        else if (b_inf)                                                 spec_val_d = n2;
        else                                                            spec_d     = 1'b0;
        // Order by magnitude so the mantissa subtraction never goes negative
        swap  = (n2[30:0] > n1[30:0]);
        big   = swap ? n2 : n1;
        sml   = swap ? n1[30:0] : n2[30:0];
        e_big = (big[30:23] == 8'd0) ? 9'd1 : {1'b0, big[30:23]};
        e_sml = (sml[30:23] == 8'd0) ? 9'd1 : {1'b0, sml[30:23]};
        m_big = {big[30:23] != 8'd0, big[22:0], 3'b000};
        m_sml = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
        diff  = e_big - e_sml;
        if (diff > 9'd26) begin
            m_sh = {26'd0, |m_sml};
        end else begin
            m_sh    = m_sml >> diff[4:0];
            m_sh[0] = m_sh[0] | (|(m_sml & ~(27'h7FFFFFF << diff[4:0])));
        end
    end

    logic [4:0]  lz;
    logic [8:0]  max_sh, sh, ne_d;
    logic [26:0] nm_d;

    // Left shift is capped so the exponent never drops below 1 (subnormal floor)
    always_comb begin
        lz     = lzc27(sum_q[26:0]);
        max_sh = exp_q - 9'd1;
        sh     = ({4'd0, lz} > max_sh) ? max_sh : {4'd0, lz};
        if (sum_q[27]) begin
            nm_d = {sum_q[27:2], sum_q[1] | sum_q[0]};
            ne_d = exp_q + 9'd1;
        end else begin
            nm_d = sum_q[26:0] << sh;
            ne_d = exp_q - sh;
        end
    end

    logic        rnd_up;
    logic [24:0] m25;
    logic [23:0] rm;
    logic [8:0]  re;
    logic [31:0] res_d;

    always_comb begin
        rnd_up = nm_q[2] & (nm_q[1] | nm_q[0] | nm_q[3]);
        m25    = {1'b0, nm_q[26:3]} + {24'd0, rnd_up};
        if (m25[24]) begin
            rm = m25[24:1];
            re = ne_q + 9'd1;
        end else begin
            rm = m25[23:0];
            re = ne_q;
        end
        if (spec_q)              res_d = spec_val_q;
        else if (zero_q)         res_d = {neg_zero_q, 31'd0};
        else if (re >= 9'd255)   res_d = {sgn_q, 8'hFF, 23'd0};
        else                     res_d = {sgn_q, rm[23] ? re[7:0] : 8'd0, rm[22:0]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= A_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        result_ready = 1'b0;
        case (state)
            A_IDLE:  if (load) state_nx = A_ALIGN;
            A_ALIGN: state_nx = A_ADD;
            A_ADD:   state_nx = A_NORM;
            A_NORM:  state_nx = A_ROUND;
            A_ROUND: state_nx = A_DONE;
            A_DONE: begin
                result_ready = 1'b1;
                if (result_ack) state_nx = A_IDLE;
            end
            default: state_nx = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n1 <= '0; n2 <= '0;
            spec_q <= 1'b0; spec_val_q <= '0;
            sgn_q <= 1'b0; eff_sub_q <= 1'b0; neg_zero_q <= 1'b0; zero_q <= 1'b0;
            exp_q <= '0; ne_q <= '0;
            ma_q <= '0; mb_q <= '0; nm_q <= '0; sum_q <= '0;
            Result <= '0;
        end else begin
            case (state)
                A_IDLE: if (load) begin
                    n1 <= Number1;
                    n2 <= Number2;
                end
                A_ALIGN: begin
                    spec_q     <= spec_d;
                    spec_val_q <= spec_val_d;
                    sgn_q      <= big[31];
                    eff_sub_q  <= n1[31] ^ n2[31];
                    neg_zero_q <= n1[31] & n2[31];
                    exp_q      <= e_big;
                    ma_q       <= m_big;
                    mb_q       <= m_sh;
                end
                A_ADD: sum_q <= eff_sub_q ? ({1'b0, ma_q} - {1'b0, mb_q})
                                          : ({1'b0, ma_q} + {1'b0, mb_q});
                A_NORM: begin
                    nm_q   <= nm_d;
                    ne_q   <= ne_d;
                    zero_q <= (sum_q == 28'd0);
                end
                A_ROUND: Result <= res_d;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_addsub_seq.sv
// tb/tb_mat_addsub_seq.sv - directed self-checking bench for mat_addsub_seq
module tb_mat_addsub_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         m_a_stb = 1'b0, m_b_stb = 1'b0, m_op = 1'b0, m_ack = 1'b0;
    logic         m_in_ack, m_busy, m_rr;
    logic [127:0] m_a = '0, m_b = '0, m_res;

    logic         t_stb = 1'b0, t_op = 1'b0, t_ack = 1'b0;
    logic         t_in_ack, t_busy, t_rr;
    logic [95:0]  t_a = '0, t_b = '0, t_res;

    logic         o_stb = 1'b0, o_op = 1'b0, o_ack = 1'b0;
    logic         o_in_ack, o_busy, o_rr;
    logic [31:0]  o_a = '0, o_b = '0, o_res;

    int checks = 0;
    int errors = 0;
    int in_ack_cnt = 0;

    mat_addsub_seq #(.ROWS(2), .COLS(2)) u_main (
        .clk(clk), .reset(reset), .A_stb(m_a_stb), .B_stb(m_b_stb), .op(m_op),
        .A(m_a), .B(m_b), .in_ack(m_in_ack), .busy(m_busy),
        .result_ready(m_rr), .result_ack(m_ack), .result(m_res)
    );

    mat_addsub_seq #(.ROWS(3), .COLS(1)) u_col (
        .clk(clk), .reset(reset), .A_stb(t_stb), .B_stb(t_stb), .op(t_op),
        .A(t_a), .B(t_b), .in_ack(t_in_ack), .busy(t_busy),
        .result_ready(t_rr), .result_ack(t_ack), .result(t_res)
    );

    mat_addsub_seq #(.ROWS(1), .COLS(1)) u_one (
        .clk(clk), .reset(reset), .A_stb(o_stb), .B_stb(o_stb), .op(o_op),
        .A(o_a), .B(o_b), .in_ack(o_in_ack), .busy(o_busy),
        .result_ready(o_rr), .result_ack(o_ack), .result(o_res)
    );

    always @(negedge clk) if (m_in_ack === 1'b1) in_ack_cnt++;

    task automatic main_start(input logic [127:0] a, input logic [127:0] b, input logic o,
                              output logic seen);
        @(negedge clk);
        m_a = a; m_b = b; m_op = o; m_a_stb = 1'b1; m_b_stb = 1'b1;
        @(negedge clk);
        seen = m_in_ack;
        m_a_stb = 1'b0; m_b_stb = 1'b0;
    endtask

    task automatic main_wait_rr(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (m_rr === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic main_release();
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
    endtask

    task automatic col_run(input logic [95:0] a, input logic [95:0] b, input logic o,
                           output logic seen, output bit ok);
        @(negedge clk);
        t_a = a; t_b = b; t_op = o; t_stb = 1'b1;
        @(negedge clk);
        seen = t_in_ack; t_stb = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (t_rr === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic one_run(input logic [31:0] a, input logic [31:0] b, input logic o,
                           output logic seen, output bit ok);
        @(negedge clk);
        o_a = a; o_b = b; o_op = o; o_stb = 1'b1;
        @(negedge clk);
        seen = o_in_ack; o_stb = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (o_rr === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({m_in_ack, m_busy, m_rr} !== 3'b000 || m_res !== 128'd0) begin
            errors++;
            $display("FAIL reset_main flags=%b result=%h required flags=000 result=0", {m_in_ack, m_busy, m_rr}, m_res);
        end
        checks++;
        if ({t_in_ack, t_busy, t_rr, o_in_ack, o_busy, o_rr} !== 6'd0 || t_res !== 96'd0 || o_res !== 32'd0) begin
            errors++;
            $display("FAIL reset_small flags=%b required 000000", {t_in_ack, t_busy, t_rr, o_in_ack, o_busy, o_rr});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_a_stb = 1'b1; m_b_stb = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (m_busy !== 1'b0 || m_in_ack !== 1'b0) begin
            errors++;
            $display("FAIL a_stb_only busy=%b in_ack=%b required 0 0", m_busy, m_in_ack);
        end
        m_a_stb = 1'b0;
    endtask

    task automatic test_add();
        logic seen; bit ok; int base;
        base = in_ack_cnt;
        main_start({4{32'h3F800000}}, {4{32'h40000000}}, 1'b0, seen);
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL add_in_ack got %b required 1", seen); end
        @(negedge clk);
        checks++;
        if (m_in_ack !== 1'b0 || m_busy !== 1'b1) begin
            errors++; $display("FAIL add_pulse in_ack=%b busy=%b required 0 1", m_in_ack, m_busy);
        end
        main_wait_rr(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL add_timeout result_ready=%b required 1", m_rr); end
        checks++;
        if (m_res !== {4{32'h40400000}}) begin
            errors++; $display("FAIL add_result got %h required %h", m_res, {4{32'h40400000}});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (m_rr !== 1'b1) begin errors++; $display("FAIL add_held result_ready=%b required 1", m_rr); end
        checks++;
        if (in_ack_cnt - base !== 1) begin
            errors++; $display("FAIL add_in_ack_count got %0d required 1", in_ack_cnt - base);
        end
        main_release();
        checks++;
        if (m_rr !== 1'b0 || m_busy !== 1'b0) begin
            errors++; $display("FAIL add_release rr=%b busy=%b required 0 0", m_rr, m_busy);
        end
    endtask

    task automatic test_sub_order();
        logic seen; bit ok;
        logic [127:0] exp_v;
        main_start({4{32'h40400000}}, {4{32'h3F800000}}, 1'b1, seen);
        main_wait_rr(ok);
        checks++;
        if (!ok || m_res !== {4{32'h40000000}}) begin
            errors++; $display("FAIL sub_uniform got %h required %h", m_res, {4{32'h40000000}});
        end
        main_release();
        main_start({32'h41000000, 32'h40800000, 32'h40000000, 32'h3F800000}, {4{32'h3F000000}}, 1'b1, seen);
        m_a = {4{32'hDEADBEEF}}; m_b = {4{32'h12345678}}; m_op = 1'b0;
        exp_v = {32'h40F00000, 32'h40600000, 32'h3FC00000, 32'h3F000000};
        main_wait_rr(ok);
        checks++;
        if (!ok || m_res !== exp_v) begin
            errors++; $display("FAIL sub_order got %h required %h", m_res, exp_v);
        end
        main_release();
    endtask

    task automatic test_hold();
        logic seen; bit ok;
        main_start({4{32'h40000000}}, {4{32'h40000000}}, 1'b0, seen);
        m_ack = 1'b1;
        repeat (5) @(negedge clk);
        m_ack = 1'b0;
        checks++;
        if (m_busy !== 1'b1 || m_rr !== 1'b0) begin
            errors++; $display("FAIL early_ack busy=%b rr=%b required 1 0", m_busy, m_rr);
        end
        main_wait_rr(ok);
        checks++;
        if (!ok || m_res !== {4{32'h40800000}}) begin
            errors++; $display("FAIL hold_result got %h required %h", m_res, {4{32'h40800000}});
        end
        for (int i = 0; i < 20; i++) begin
            m_a_stb = ~m_a_stb; m_b_stb = m_a_stb;
            m_a = {4{$urandom}}; m_b = {4{$urandom}};
            @(negedge clk);
            checks++;
            if (m_rr !== 1'b1 || m_in_ack !== 1'b0 || m_res !== {4{32'h40800000}}) begin
                errors++;
                $display("FAIL hold_cycle %0d rr=%b in_ack=%b result=%h required 1 0 %h", i, m_rr, m_in_ack, m_res, {4{32'h40800000}});
            end
        end
        m_a_stb = 1'b0; m_b_stb = 1'b0;
        main_release();
        checks++;
        if (m_rr !== 1'b0 || m_busy !== 1'b0 || m_in_ack !== 1'b0) begin
            errors++; $display("FAIL hold_release rr=%b busy=%b in_ack=%b required 0 0 0", m_rr, m_busy, m_in_ack);
        end
    endtask

    task automatic test_reset_mid();
        logic seen; bit ok; bit stray;
        main_start({4{32'h3F800000}}, {4{32'h3F800000}}, 1'b0, seen);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (u_main.adder_load === 1'b1 && u_main.k === 2'd2) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach element2 load not seen, required seen"); end
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({m_in_ack, m_busy, m_rr} !== 3'b000 || m_res !== 128'd0) begin
            errors++;
            $display("FAIL mid_reset flags=%b result=%h required flags=000 result=0", {m_in_ack, m_busy, m_rr}, m_res);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (m_rr !== 1'b0 || m_busy !== 1'b0) stray = 1'b1;
        end
        checks++;
        if (stray) begin errors++; $display("FAIL mid_discard stray activity seen, required none"); end
        main_start({4{32'h40400000}}, {4{32'h40000000}}, 1'b0, seen);
        main_wait_rr(ok);
        checks++;
        if (seen !== 1'b1 || !ok || m_res !== {4{32'h40A00000}}) begin
            errors++; $display("FAIL mid_after in_ack=%b result=%h required 1 %h", seen, m_res, {4{32'h40A00000}});
        end
        main_release();
    endtask

    task automatic test_small_shapes();
        logic seen; bit ok;
        col_run({32'h40000000, 32'h3F800000, 32'h00000000}, {32'h40000000, 32'hBF800000, 32'h80000000}, 1'b0, seen, ok);
        checks++;
        if (seen !== 1'b1 || !ok || t_res !== {32'h40800000, 32'h00000000, 32'h00000000}) begin
            errors++; $display("FAIL col_zero in_ack=%b result=%h required 1 %h", seen, t_res, {32'h40800000, 64'd0});
        end
        t_ack = 1'b1; @(negedge clk); t_ack = 1'b0;
        checks++;
        if (t_rr !== 1'b0) begin errors++; $display("FAIL col_release rr=%b required 0", t_rr); end
        col_run({32'h00000000, 32'h40800000, 32'h3F800000}, {32'h00000000, 32'h3F000000, 32'h3F000000}, 1'b1, seen, ok);
        checks++;
        if (!ok || t_res !== {32'h00000000, 32'h40600000, 32'h3F000000}) begin
            errors++; $display("FAIL col_sub result=%h required %h", t_res, {32'h00000000, 32'h40600000, 32'h3F000000});
        end
        t_ack = 1'b1; @(negedge clk); t_ack = 1'b0;
        one_run(32'h3F800000, 32'hBF800000, 1'b0, seen, ok);
        checks++;
        if (seen !== 1'b1 || !ok || o_res !== 32'h00000000) begin
            errors++; $display("FAIL one_cancel in_ack=%b result=%h required 1 00000000", seen, o_res);
        end
        o_ack = 1'b1; @(negedge clk); o_ack = 1'b0;
        one_run(32'h3F800000, 32'h80000000, 1'b1, seen, ok);
        checks++;
        if (!ok || o_res !== 32'h3F800000) begin
            errors++; $display("FAIL one_sub_zero result=%h required 3f800000", o_res);
        end
        o_ack = 1'b1; @(negedge clk); o_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] a_v [3];
        logic [127:0] b_v [3];
        logic [127:0] e_v [3];
        logic         o_v [3];
        bit ok; int base;
        a_v[0] = {4{32'h3F800000}}; b_v[0] = {4{32'h3F800000}}; o_v[0] = 1'b0; e_v[0] = {4{32'h40000000}};
        a_v[1] = {4{32'h40000000}}; b_v[1] = {4{32'h3F000000}}; o_v[1] = 1'b1; e_v[1] = {4{32'h3FC00000}};
        a_v[2] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000}; b_v[2] = {4{32'h3F800000}};
        o_v[2] = 1'b0; e_v[2] = {32'h40A00000, 32'h40800000, 32'h40400000, 32'h40000000};
        base = in_ack_cnt;
        @(negedge clk);
        m_a = a_v[0]; m_b = b_v[0]; m_op = o_v[0]; m_a_stb = 1'b1; m_b_stb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ok = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (m_in_ack === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok) begin errors++; $display("FAIL b2b_in_ack op %0d not seen, required pulse", i); end
            if (i < 2) begin
                m_a = a_v[i+1]; m_b = b_v[i+1]; m_op = o_v[i+1];
            end else begin
                m_a_stb = 1'b0; m_b_stb = 1'b0;
            end
            main_wait_rr(ok);
            checks++;
            if (!ok || m_res !== e_v[i]) begin
                errors++; $display("FAIL b2b_result op %0d got %h required %h", i, m_res, e_v[i]);
            end
            main_release();
        end
        repeat (20) @(negedge clk);
        checks++;
        if (in_ack_cnt - base !== 3 || m_busy !== 1'b0) begin
            errors++; $display("FAIL b2b_count in_acks=%0d busy=%b required 3 0", in_ack_cnt - base, m_busy);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_order();
        test_hold();
        test_reset_mid();
        test_small_shapes();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mat_addsub_seq.md
MAT_ADDSUB_SEQ -- requirements
Module: mat_addsub_seq

Interface
REQ-001 SHALL have parameter ROWS, default 2, matrix row count (>=1).
REQ-002 SHALL have parameter COLS, default 2, matrix column count (>=1); N = ROWS*COLS elements, each IEEE-754 single (32 bit).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 A_stb  input  1  operand A valid.
REQ-006 B_stb  input  1  operand B valid.
REQ-007 op  input  1  0 = A+B, 1 = A-B; sampled at acceptance only.
REQ-008 A  input  32*N  element k = r*COLS+c at bits [k*32 +: 32] (row-major).
REQ-009 B  input  32*N  same packing as A.
REQ-010 in_ack  output  1  one-cycle pulse when A, B, op are captured.
REQ-011 busy  output  1  high in every state except S_IDLE.
REQ-012 result_ready  output  1  result valid, held until acknowledged.
REQ-013 result_ack  input  1  consumer acknowledge of result.
REQ-014 result  output  32*N  element-wise result, same packing as A.

Function
REQ-015 SHALL instantiate one team floating-point adder `adder` (ports reset, clk, load, Number1, Number2, result_ready, result_ack, Result) shared across all N elements.
REQ-016 SHALL implement states S_IDLE, S_LOAD, S_WAIT, S_ACK, S_DONE.
REQ-017 S_IDLE: when A_stb && B_stb, capture A, B, op into internal registers, pulse in_ack, set k=0, go S_LOAD; else stay.
REQ-018 S_LOAD: drive Number1 = A[k], Number2 = B[k] with bit 31 XORed with captured op, assert adder load for exactly one cycle, go S_WAIT.
REQ-019 S_WAIT: adder load low; on adder result_ready store Result into result element k, assert adder result_ack, go S_ACK.
REQ-020 S_ACK: hold adder result_ack high until adder result_ready is low; then deassert ack; if k == N-1 go S_DONE, else k=k+1 and go S_LOAD.
REQ-021 S_DONE: drive result_ready high; result SHALL be stable while high; on result_ack sampled high, drop result_ready next cycle and go S_IDLE.
REQ-022 Element counter SHALL be clog2(N) bits (min 1) and SHALL never exceed N-1.
REQ-023 A_stb/B_stb while busy SHALL be ignored (no in_ack, no capture); input buses may change freely after in_ack.
REQ-024 result_ack outside S_DONE SHALL be ignored.
REQ-025 A_stb && B_stb high in the S_IDLE cycle entered from S_DONE SHALL start a new operation (back-to-back supported).
REQ-026 Subtraction SHALL be exact sign inversion of B (including zero, Inf, NaN); rounding/special values are the adder's behaviour.
REQ-027 result elements not yet written in current operation SHALL retain previous operation values until overwritten.
REQ-028 Latency from in_ack to result_ready = sum over elements of (1 load + adder latency + ack cycles) + 1; no fixed bound imposed beyond the adder.

Reset
REQ-029 reset low SHALL immediately force S_IDLE, k=0, in_ack=0, busy=0, result_ready=0, result=0, adder load=0, adder result_ack=0, regardless of state.
REQ-030 reset SHALL be routed to the adder; an operation interrupted by reset SHALL be discarded with no result_ready.
REQ-031 After reset release, first accepted operation SHALL behave identically to one after power-up.

Verification
REQ-032 2x2, op=0, A all 0x3F800000 (1.0), B all 0x40000000 (2.0) -> one in_ack pulse, result all 0x40400000 (3.0), result_ready until ack.
REQ-033 2x2, op=1, A all 0x40400000, B all 0x3F800000 -> result all 0x40000000; element order checked with distinct per-element values (1.0,2.0,4.0,8.0 minus 0.5 each).
REQ-034 result_ack held low 20 cycles, A_stb/B_stb toggled meanwhile -> result and result_ready stable, no in_ack, then ack -> S_IDLE.
REQ-035 reset asserted while in S_WAIT of element 2 -> all outputs 0 next edge-independent; new op after release yields correct result.
REQ-036 ROWS=3, COLS=1 and ROWS=1, COLS=1 builds, op=0 with 0x00000000+0x80000000 and 1.0+(-1.0) -> correct packing and adder-defined zero result.
REQ-037 Back-to-back: strobes held high continuously over 3 operations -> 3 in_ack pulses, each result matches its captured operands and op.
